// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU (alu_seq) and its
// serial shift unit.
//   - 4-bit function codes ALU_ADD..ALU_PASS (opcode[3:0])
//   - bit positions of the {Z,C,S,P,V} flags in the 5-bit flag word
//   - FSM state encoding IDLE / SHIFT / DONE
//   - isShiftOp(): identifies the serial shift/rotate functions
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADC  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SBC  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_XNOR = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_ROL  = 4'd11;
  localparam logic [3:0] ALU_ROR  = 4'd12;
  localparam logic [3:0] ALU_RLC  = 4'd13;
  localparam logic [3:0] ALU_RRC  = 4'd14;
  localparam logic [3:0] ALU_PASS = 4'd15;

  localparam int FLG_Z = 4;
  localparam int FLG_C = 3;
  localparam int FLG_S = 2;
  localparam int FLG_P = 1;
  localparam int FLG_V = 0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Shift and rotate functions occupy the contiguous code range SLL..RRC.
  function automatic logic isShiftOp(input logic [3:0] func);
    return (func >= ALU_SLL) && (func <= ALU_RRC);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: serial shifter/rotator taking one bit step per cycle.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      load data/cin/mode and the step count k (k must be >= 1)
//   mode       function code ALU_SLL..ALU_RRC selecting the step type
//   k          number of single-bit steps to perform
//   cin        initial carry; seeds the {C,A} ring for RLC/RRC
//   data       value to be shifted, captured on start
//   done       high in the cycle whose step is the final one
//   result     data value after the current cycle's step
//   carry      carry bit after the current cycle's step
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHW    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic [SHW-1:0]    k,
  input  logic              cin,
  input  logic [DATA_W-1:0] data,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W-1:0] data_q;
  logic              carry_q;
  logic [SHW-1:0]    cnt_q;
  logic [3:0]        mode_q;
  logic [DATA_W-1:0] stepData;
  logic              stepCarry;

  // One bit step of the selected shift/rotate. RLC/RRC feed the carry into
  // the vacated bit so the ring is DATA_W+1 bits wide; every other mode
  // just records the bit that falls off the end.
  always_comb begin
    stepData  = data_q;
    stepCarry = carry_q;
    case (mode_q)
      ALU_SLL: begin
        stepData  = {data_q[DATA_W-2:0], 1'b0};
        stepCarry = data_q[DATA_W-1];
      end
      ALU_SRL: begin
        stepData  = {1'b0, data_q[DATA_W-1:1]};
        stepCarry = data_q[0];
      end
      ALU_SRA: begin
        stepData  = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
        stepCarry = data_q[0];
      end
      ALU_ROL: begin
        stepData  = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
        stepCarry = data_q[DATA_W-1];
      end
      ALU_ROR: begin
        stepData  = {data_q[0], data_q[DATA_W-1:1]};
        stepCarry = data_q[0];
      end
      ALU_RLC: begin
        stepData  = {data_q[DATA_W-2:0], carry_q};
        stepCarry = data_q[DATA_W-1];
      end
      ALU_RRC: begin
        stepData  = {carry_q, data_q[DATA_W-1:1]};
        stepCarry = data_q[0];
      end
      default: begin
        stepData  = data_q;
        stepCarry = carry_q;
      end
    endcase
  end

  assign result = stepData;
  assign carry  = stepCarry;
  assign done   = (cnt_q == SHW'(1));

  // Load on start, then step and count down until the counter empties.
  // The top samples result/carry in the cycle where done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= ALU_ADD;
    end else if (start) begin
      data_q  <= data;
      carry_q <= cin;
      cnt_q   <= k;
      mode_q  <= mode;
    end else if (cnt_q != '0) begin
      data_q  <= stepData;
      carry_q <= stepCarry;
      cnt_q   <= cnt_q - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes, registered result
// and {Z,C,S,P,V} flags, and a serial multi-cycle shift/rotate path.
// Ports:
//   clkout, rst          clock and synchronous active-high reset
//   in_valid, in_ready   operation request handshake
//   opcode               [4] selects X (1 = val, 0 = B), [3:0] function
//   A, B, val, cin       operands and carry in, captured at acceptance
//   out_valid, out_ready result handshake
//   result, flags        registered result and {Z,C,S,P,V}
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHW    = $clog2(DATA_W)
) (
  input  logic              clkout,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] val,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        flags
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        flags_q, flags_d;

  logic [3:0]        func;
  logic [DATA_W-1:0] opX;
  logic [SHW-1:0]    shAmt;
  logic              accept;
  logic              shiftNow;
  logic              shStart;
  logic              shDone;
  logic [DATA_W-1:0] shRes;
  logic              shCarry;
  logic [DATA_W:0]   arith;
  logic [DATA_W-1:0] aluRes;
  logic              aluC;
  logic              aluV;
  logic [4:0]        aluFlags;
  logic [4:0]        shFlags;

  assign func     = opcode[3:0];
  assign opX      = opcode[4] ? val : B;
  assign shAmt    = opX[SHW-1:0];
  assign shiftNow = isShiftOp(func) && (shAmt != '0);

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  alu_shift_unit #(
    .DATA_W(DATA_W),
    .SHW   (SHW)
  ) u_shift (
    .clk   (clkout),
    .rst   (rst),
    .start (shStart),
    .mode  (func),
    .k     (shAmt),
    .cin   (cin),
    .data  (A),
    .done  (shDone),
    .result(shRes),
    .carry (shCarry)
  );

  // Single-cycle datapath. Arithmetic runs at DATA_W+1 bits so the top bit
  // is the carry for additions and the borrow for subtractions. Shift codes
  // only reach this path with a zero amount, where the result is A and only
  // the through-carry rotates pass cin on to C.
  always_comb begin
    arith  = '0;
    aluRes = A;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (func)
      ALU_ADD, ALU_ADC: begin
        arith  = {1'b0, A} + {1'b0, opX}
                 + ((func == ALU_ADC) ? {{DATA_W{1'b0}}, cin} : '0);
        aluRes = arith[DATA_W-1:0];
        aluC   = arith[DATA_W];
        aluV   = (A[DATA_W-1] == opX[DATA_W-1]) && (aluRes[DATA_W-1] != A[DATA_W-1]);
      end
      ALU_SUB, ALU_SBC: begin
        arith  = {1'b0, A} - {1'b0, opX}
                 - ((func == ALU_SBC) ? {{DATA_W{1'b0}}, cin} : '0);
        aluRes = arith[DATA_W-1:0];
        aluC   = arith[DATA_W];
        aluV   = (A[DATA_W-1] != opX[DATA_W-1]) && (aluRes[DATA_W-1] != A[DATA_W-1]);
      end
      ALU_AND:  aluRes = A & opX;
      ALU_OR:   aluRes = A | opX;
      ALU_XOR:  aluRes = A ^ opX;
      ALU_XNOR: aluRes = ~(A ^ opX);
      ALU_PASS: aluRes = opX;
      ALU_RLC, ALU_RRC: begin
        aluRes = A;
        aluC   = cin;
      end
      default: begin
        aluRes = A;
        aluC   = 1'b0;
      end
    endcase
  end

  // Flag words for the two ways a result can be completed.
  always_comb begin
    aluFlags        = '0;
    aluFlags[FLG_Z] = (aluRes == '0);
    aluFlags[FLG_C] = aluC;
    aluFlags[FLG_S] = aluRes[DATA_W-1];
    aluFlags[FLG_P] = ^aluRes;
    aluFlags[FLG_V] = aluV;
    shFlags         = '0;
    shFlags[FLG_Z]  = (shRes == '0);
    shFlags[FLG_C]  = shCarry;
    shFlags[FLG_S]  = shRes[DATA_W-1];
    shFlags[FLG_P]  = ^shRes;
    shFlags[FLG_V]  = 1'b0;
  end

  // Control FSM. A new operation may be accepted from IDLE or from DONE in
  // the same cycle the previous result is taken, which keeps single-cycle
  // ops flowing at one per cycle. result/flags only change when an op
  // completes, so they hold the last completed op during SHIFT.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    shStart  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (shiftNow) begin
            state_d = SHIFT;
            shStart = 1'b1;
          end else begin
            state_d  = DONE;
            result_d = aluRes;
            flags_d  = aluFlags;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shDone) begin
          state_d  = DONE;
          result_d = shRes;
          flags_d  = shFlags;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clkout) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule
